// File: rtl/lcd_spi_receiver_pkg.sv
//==============================================================================
// Module : lcd_spi_receiver_pkg
// Brief  : Shared constants for the LCD serial receiver: SPI_In bit positions,
//          FSM state encoding, command opcodes and framebuffer field widths.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package lcd_spi_receiver_pkg;

   // Bit positions inside the 4-bit SPI_In bundle
   localparam int CS_N_BIT = 3;
   localparam int A0_BIT   = 2;
   localparam int SCLK_BIT = 1;
   localparam int SDA_BIT  = 0;

   // Synchronizer reset value: CS_N high, SCLK high, so no edge is seen at release
   localparam logic [3:0] SYNC_RESET_VAL = 4'b1010;

   // Receiver state encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Command opcodes live in the upper nibble
   localparam logic [7:0] OPC_MASK   = 8'hF0;
   localparam logic [7:0] OPC_PAGE   = 8'hB0;
   localparam logic [7:0] OPC_COL_HI = 8'h10;
   localparam logic [7:0] OPC_COL_LO = 8'h00;

   // Framebuffer address fields: {page, column}
   localparam int PAGE_W = 3;
   localparam int COL_W  = 7;
   localparam int ADDR_W = PAGE_W + COL_W;

   // True when the command byte carries the given opcode in its upper nibble
   function automatic logic is_opcode(input logic [7:0] cmd, input logic [7:0] opc);
      return (cmd & OPC_MASK) == opc;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_spi_receiver_if.sv
//==============================================================================
// Module : lcd_spi_receiver_if
// Brief  : Serial input bundle and framebuffer/command outputs of the receiver.
//          slave = receiver side, master = bus driver / consumer side.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface lcd_spi_receiver_if;
   import lcd_spi_receiver_pkg::*;

   logic [3:0]        SPI_In;
   logic              Write_En_Sig;
   logic [ADDR_W-1:0] Write_Addr_Sig;
   logic [7:0]        Write_Data;
   logic              Cmd_Sig;
   logic [7:0]        Cmd_Data;

   modport slave (
      input  SPI_In,
      output Write_En_Sig,
      output Write_Addr_Sig,
      output Write_Data,
      output Cmd_Sig,
      output Cmd_Data
   );

   modport master (
      output SPI_In,
      input  Write_En_Sig,
      input  Write_Addr_Sig,
      input  Write_Data,
      input  Cmd_Sig,
      input  Cmd_Data
   );

endinterface

`default_nettype wire

// File: rtl/lcd_spi_receiver_spi_in_sync.sv
//==============================================================================
// Module : spi_in_sync
// Brief  : Two-flop synchronizer for the four SPI_In lines plus an SCLK
//          rising-edge detector working on the synchronized clock line.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module spi_in_sync
   import lcd_spi_receiver_pkg::*;
(
   input  wire logic       clk,
   input  wire logic       rst_n,
   input  wire logic [3:0] spi_raw,
   output logic      [3:0] spi_sync,
   output logic            sclk_rise
);

   logic [3:0] meta;
   logic       sclk_prev;

   // Two-stage synchronizer plus previous-SCLK flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta      <= SYNC_RESET_VAL;
         spi_sync  <= SYNC_RESET_VAL;
         sclk_prev <= 1'b1;
      end else begin
         meta      <= spi_raw;
         spi_sync  <= meta;
         sclk_prev <= spi_sync[SCLK_BIT];
      end
   end

   assign sclk_rise = spi_sync[SCLK_BIT] & ~sclk_prev;

endmodule

`default_nettype wire

// File: rtl/lcd_spi_receiver.sv
//==============================================================================
// Module : lcd_spi_receiver
// Brief  : LCD serial receiver. Assembles 8-bit bytes from SDA, then either
//          writes display data at {page, col} (auto-incrementing col) or
//          reports/decodes a command (page select, column high/low nibble).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module lcd_spi_receiver
   import lcd_spi_receiver_pkg::*;
#(
   parameter int COLUMNS = 128,
   parameter int PAGES   = 8
) (
   input  wire logic          CLK,
   input  wire logic          RSTn,
   lcd_spi_receiver_if.slave  bus
);

   logic [3:0]       spi_sync;
   logic             sclk_rise;
   logic             cs_n;
   logic             a0;
   logic             sda;

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic [2:0]       bit_cnt;
   logic [6:0]       shreg;        // first seven bits of the byte in flight
   logic [PAGE_W-1:0] page;
   logic [COL_W-1:0] col;

   logic             shift_en;
   logic             byte_done;
   logic [7:0]       rx_byte;

   spi_in_sync u_sync (
      .clk       (CLK),
      .rst_n     (RSTn),
      .spi_raw   (bus.SPI_In),
      .spi_sync  (spi_sync),
      .sclk_rise (sclk_rise)
   );

   assign cs_n = spi_sync[CS_N_BIT];
   assign a0   = spi_sync[A0_BIT];
   assign sda  = spi_sync[SDA_BIT];

   // State register
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Next-state logic; a high CS_N always forces IDLE
   always_comb begin
      state_next = state;
      if (cs_n) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  state_next = ST_SHIFT;
            ST_SHIFT: if (byte_done) state_next = ST_DONE;
            ST_DONE:  state_next = ST_SHIFT;
            default:  state_next = ST_IDLE;
         endcase
      end
   end

   // Per-cycle controls: sample on a detected edge while selected, byte ends on bit 8
   always_comb begin
      shift_en  = sclk_rise & ~cs_n & (state != ST_IDLE);
      byte_done = shift_en & (bit_cnt == 3'd7);
      rx_byte   = {shreg, sda};
   end

   // Bit counter and shifter; deselect throws away any partial byte
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         bit_cnt <= 3'd0;
         shreg   <= 7'd0;
      end else if (cs_n) begin
         bit_cnt <= 3'd0;
         shreg   <= 7'd0;
      end else if (shift_en) begin
         bit_cnt <= bit_cnt + 3'd1;
         shreg   <= {shreg[5:0], sda};
      end
   end

   // Byte completion: data write with column auto-increment, or command decode
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         page               <= '0;
         col                <= '0;
         bus.Write_En_Sig   <= 1'b0;
         bus.Write_Addr_Sig <= '0;
         bus.Write_Data     <= 8'd0;
         bus.Cmd_Sig        <= 1'b0;
         bus.Cmd_Data       <= 8'd0;
      end else begin
         bus.Write_En_Sig <= 1'b0;
         bus.Cmd_Sig      <= 1'b0;
         if (byte_done) begin
            if (a0) begin
               bus.Write_En_Sig   <= 1'b1;
               bus.Write_Addr_Sig <= {page, col};
               bus.Write_Data     <= rx_byte;
               col <= (col == COL_W'(COLUMNS - 1)) ? '0 : col + 1'b1;
            end else begin
               bus.Cmd_Sig  <= 1'b1;
               bus.Cmd_Data <= rx_byte;
               if (is_opcode(rx_byte, OPC_PAGE)) begin
                  // Out-of-range page numbers are reported but not applied
                  if (int'(rx_byte[3:0]) < PAGES) page <= rx_byte[PAGE_W-1:0];
               end else if (is_opcode(rx_byte, OPC_COL_HI)) begin
                  col[6:4] <= rx_byte[2:0];
               end else if (is_opcode(rx_byte, OPC_COL_LO)) begin
                  col[3:0] <= rx_byte[3:0];
               end
            end
         end
      end
   end

endmodule

`default_nettype wire
